// File: rtl/atm_pkg.sv
// Shared types for the ATM session controller: FSM states, op codes and error codes.
// The optional PIN-change operation is controlled by the ATM_PIN_CHANGE_EN macro.
package atm_pkg;

  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StPin    = 4'd1,
    StMenu   = 4'd2,
    StDep    = 4'd3,
    StWdr    = 4'd4,
    StCheck  = 4'd5,
    StUpdate = 4'd6,
    StShow   = 4'd7,
    StPinChg = 4'd8,
    StEject  = 4'd9,
    StRetain = 4'd10
  } state_e;

  typedef enum logic [2:0] {
    ErrNone     = 3'd0,
    ErrBadPin   = 3'd1,
    ErrInsuff   = 3'd2,
    ErrOverflow = 3'd3,
    ErrLimit    = 3'd4,
    ErrTimeout  = 3'd5,
    ErrBadOp    = 3'd6,
    ErrLocked   = 3'd7
  } err_e;

  localparam logic [2:0] OpNone      = 3'd0;
  localparam logic [2:0] OpBalance   = 3'd1;
  localparam logic [2:0] OpDeposit   = 3'd2;
  localparam logic [2:0] OpWithdraw  = 3'd3;
  localparam logic [2:0] OpPinChange = 3'd4;

endpackage

// File: rtl/atm_multi_account_ctrl_if.sv
// Front-end / dispenser bundle of the ATM session controller.
// slave: the controller. master: the card/keypad front end (or a bench).
interface atm_multi_account_ctrl_if #(
  parameter int unsigned ACCT_W = 2,
  parameter int unsigned BAL_W  = 32,
  parameter int unsigned PIN_W  = 4
);
  logic              card_in;
  logic [ACCT_W-1:0] card_acct;
  logic              pin_valid;
  logic [PIN_W-1:0]  pin;
  logic              op_valid;
  logic [2:0]        op_code;
  logic              amt_valid;
  logic [BAL_W-1:0]  amount;
  logic              eject_req;
  logic [3:0]        state_o;
  logic [BAL_W-1:0]  balance_o;
  logic              balance_valid;
  logic              dispense_valid;
  logic [BAL_W-1:0]  dispense_amt;
  logic [2:0]        err_o;
  logic              card_eject;
  logic              card_retained;

  modport master (
    output card_in, card_acct, pin_valid, pin, op_valid, op_code, amt_valid, amount, eject_req,
    input  state_o, balance_o, balance_valid, dispense_valid, dispense_amt, err_o, card_eject,
           card_retained
  );

  modport slave (
    input  card_in, card_acct, pin_valid, pin, op_valid, op_code, amt_valid, amount, eject_req,
    output state_o, balance_o, balance_valid, dispense_valid, dispense_amt, err_o, card_eject,
           card_retained
  );
endinterface

// File: rtl/atm_account_bank.sv
// Per-account balance, PIN and lock storage; one combinational read port, one write port.
// PIN storage exists only when ATM_PIN_CHANGE_EN is defined; otherwise every PIN is DEFAULT_PIN.
module atm_account_bank #(
  parameter int unsigned      NUM_ACCT    = 4,
  parameter int unsigned      ACCT_W      = 2,
  parameter int unsigned      BAL_W       = 32,
  parameter int unsigned      PIN_W       = 4,
  parameter logic [BAL_W-1:0] INIT_BAL    = BAL_W'(1000000),
  parameter logic [PIN_W-1:0] DEFAULT_PIN = PIN_W'(4'b1010)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ACCT_W-1:0] rd_idx,
  output logic [BAL_W-1:0]  rd_bal,
  output logic [PIN_W-1:0]  rd_pin,
  output logic              rd_lock,
  input  logic [ACCT_W-1:0] wr_idx,
  input  logic              bal_we,
  input  logic [BAL_W-1:0]  bal_wdata,
  input  logic              pin_we,
  input  logic [PIN_W-1:0]  pin_wdata,
  input  logic              lock_set
);
  logic [BAL_W-1:0]    bal_q [NUM_ACCT];
  logic [NUM_ACCT-1:0] lock_q;

  // Balances and lock flags; locks are sticky until reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NUM_ACCT); i++) bal_q[i] <= INIT_BAL;
      lock_q <= '0;
    end else begin
      if (bal_we) bal_q[wr_idx] <= bal_wdata;
      if (lock_set) lock_q[wr_idx] <= 1'b1;
    end
  end

  assign rd_bal  = bal_q[rd_idx];
  assign rd_lock = lock_q[rd_idx];

`ifdef ATM_PIN_CHANGE_EN
  logic [PIN_W-1:0] pin_q [NUM_ACCT];

  // Per-account PINs, rewritten by the PIN-change operation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NUM_ACCT); i++) pin_q[i] <= DEFAULT_PIN;
    end else if (pin_we) begin
      pin_q[wr_idx] <= pin_wdata;
    end
  end

  assign rd_pin = pin_q[rd_idx];
`else
  logic unused_pin;
  assign unused_pin = ^{pin_we, pin_wdata};
  assign rd_pin     = DEFAULT_PIN;
`endif

endmodule

// File: rtl/atm_multi_account_ctrl.sv
// ATM session controller: card accept, PIN check with lockout, balance/deposit/withdraw,
// per-session withdrawal limit and inactivity timeout. All outputs are registered and
// follow the FSM state by one cycle. Optional macro: ATM_PIN_CHANGE_EN (op code 4).
module atm_multi_account_ctrl
  import atm_pkg::*;
#(
  parameter int unsigned      NUM_ACCT    = 4,
  parameter int unsigned      BAL_W       = 32,
  parameter int unsigned      PIN_W       = 4,
  parameter logic [BAL_W-1:0] INIT_BAL    = BAL_W'(1000000),
  parameter logic [PIN_W-1:0] DEFAULT_PIN = PIN_W'(4'b1010),
  parameter int unsigned      MAX_TRIES   = 3,
  parameter int unsigned      TIMEOUT_CYC = 1024,
  parameter logic [BAL_W-1:0] WDR_LIMIT   = BAL_W'(50000)
) (
  input  logic clk,
  input  logic reset_n,
  atm_multi_account_ctrl_if.slave bus
);
  localparam int unsigned ACCT_W = (NUM_ACCT > 1) ? $clog2(NUM_ACCT) : 1;
  localparam int unsigned TRY_W  = $clog2(MAX_TRIES + 1);
  localparam int unsigned TMR_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMR_W-1:0] TmrLast = TMR_W'(TIMEOUT_CYC - 1);

  state_e            state_q, state_d;
  logic [ACCT_W-1:0] acct_q, acct_d, rd_idx;
  logic [TRY_W-1:0]  tries_q, tries_d;
  logic              dep_q, dep_d;
  logic [BAL_W-1:0]  amt_q, amt_d, wdr_q, wdr_d;
  logic [TMR_W-1:0]  timer_q;
  err_e              err_q, err_d;
  logic              strobe, timed, last_try;

  logic [BAL_W-1:0]  rd_bal, bal_wdata;
  logic [PIN_W-1:0]  rd_pin, pin_wdata;
  logic              rd_lock, bal_we, pin_we, lock_set;
  logic [BAL_W:0]    dep_sum, wdr_sum;

  // In IDLE the lock flag of the offered card is needed before the account is latched.
  assign rd_idx    = (state_q == StIdle) ? bus.card_acct : acct_q;
  assign dep_sum   = {1'b0, rd_bal} + {1'b0, amt_q};
  assign wdr_sum   = {1'b0, wdr_q} + {1'b0, amt_q};
  assign last_try  = (32'(tries_q) + 32'd1) >= MAX_TRIES;
  assign pin_wdata = bus.amount[PIN_W-1:0];

  atm_account_bank #(
    .NUM_ACCT    (NUM_ACCT),
    .ACCT_W      (ACCT_W),
    .BAL_W       (BAL_W),
    .PIN_W       (PIN_W),
    .INIT_BAL    (INIT_BAL),
    .DEFAULT_PIN (DEFAULT_PIN)
  ) u_bank (
    .clk       (clk),
    .reset_n   (reset_n),
    .rd_idx    (rd_idx),
    .rd_bal    (rd_bal),
    .rd_pin    (rd_pin),
    .rd_lock   (rd_lock),
    .wr_idx    (acct_q),
    .bal_we    (bal_we),
    .bal_wdata (bal_wdata),
    .pin_we    (pin_we),
    .pin_wdata (pin_wdata),
    .lock_set  (lock_set)
  );

  // States in which the inactivity timer runs (PIN change behaves like DEP/WDR).
  always_comb begin
    timed = state_q inside {StPin, StMenu, StDep, StWdr, StShow};
`ifdef ATM_PIN_CHANGE_EN
    if (state_q == StPinChg) timed = 1'b1;
`endif
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Next state, datapath next values and bank write controls.
  always_comb begin
    state_d   = state_q;
    acct_d    = acct_q;
    tries_d   = tries_q;
    dep_d     = dep_q;
    amt_d     = amt_q;
    wdr_d     = wdr_q;
    err_d     = err_q;
    strobe    = 1'b0;
    bal_we    = 1'b0;
    bal_wdata = dep_q ? dep_sum[BAL_W-1:0] : rd_bal - amt_q;
    pin_we    = 1'b0;
    lock_set  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.card_in) begin
          acct_d  = bus.card_acct;
          tries_d = '0;
          if (rd_lock) begin
            err_d   = ErrLocked;
            state_d = StEject;
          end else begin
            err_d   = ErrNone;
            state_d = StPin;
          end
        end
      end
      StPin: begin
        if (bus.pin_valid) begin
          strobe = 1'b1;
          if (bus.pin == rd_pin) begin
            err_d   = ErrNone;
            state_d = StMenu;
          end else begin
            tries_d = tries_q + TRY_W'(1);
            if (last_try) begin
              lock_set = 1'b1;
              err_d    = ErrLocked;
              state_d  = StRetain;
            end else begin
              err_d = ErrBadPin;
            end
          end
        end
      end
      StMenu, StShow: begin
        if (bus.eject_req) begin
          strobe  = 1'b1;
          err_d   = ErrNone;
          state_d = StEject;
        end else if (bus.op_valid) begin
          strobe = 1'b1;
          err_d  = ErrNone;
          case (bus.op_code)
            OpNone:     ;
            OpBalance:  state_d = StShow;
            OpDeposit: begin
              dep_d   = 1'b1;
              state_d = StDep;
            end
            OpWithdraw: begin
              dep_d   = 1'b0;
              state_d = StWdr;
            end
`ifdef ATM_PIN_CHANGE_EN
            OpPinChange: state_d = StPinChg;
`endif
            default:    err_d = ErrBadOp;
          endcase
        end
      end
      StDep, StWdr: begin
        if (bus.amt_valid) begin
          strobe  = 1'b1;
          err_d   = ErrNone;
          amt_d   = bus.amount;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (dep_q) begin
          if (dep_sum[BAL_W]) begin
            err_d   = ErrOverflow;
            state_d = StMenu;
          end else begin
            state_d = StUpdate;
          end
        end else if (amt_q > rd_bal) begin
          err_d   = ErrInsuff;
          state_d = StWdr;
        end else if (wdr_sum > {1'b0, WDR_LIMIT}) begin
          err_d   = ErrLimit;
          state_d = StWdr;
        end else begin
          state_d = StUpdate;
        end
      end
      StUpdate: begin
        bal_we = 1'b1;
        if (!dep_q) wdr_d = wdr_sum[BAL_W-1:0];
        state_d = StShow;
      end
`ifdef ATM_PIN_CHANGE_EN
      StPinChg: begin
        if (bus.amt_valid) begin
          strobe  = 1'b1;
          err_d   = ErrNone;
          pin_we  = 1'b1;
          state_d = StShow;
        end
      end
`endif
      StEject: begin
        wdr_d   = '0;
        state_d = StIdle;
      end
      StRetain: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    // An accepted strobe on the last idle cycle still wins over the timeout.
    if (timed && !strobe && (timer_q == TmrLast)) begin
      err_d   = ErrTimeout;
      state_d = StEject;
    end
  end

  // Session datapath registers and inactivity timer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acct_q  <= '0;
      tries_q <= '0;
      dep_q   <= 1'b0;
      amt_q   <= '0;
      wdr_q   <= '0;
      err_q   <= ErrNone;
      timer_q <= '0;
    end else begin
      acct_q  <= acct_d;
      tries_q <= tries_d;
      dep_q   <= dep_d;
      amt_q   <= amt_d;
      wdr_q   <= wdr_d;
      err_q   <= err_d;
      if (!timed || strobe || (state_d != state_q)) timer_q <= '0;
      else                                          timer_q <= timer_q + TMR_W'(1);
    end
  end

  logic [3:0]       state_o_d, state_o_q;
  logic [BAL_W-1:0] balance_d, balance_q, disp_amt_d, disp_amt_q;
  logic             bal_valid_d, bal_valid_q, disp_valid_d, disp_valid_q;
  logic             eject_d, eject_q, retain_d, retain_q;
  logic [2:0]       err_o_q;

  // Output decode from the current state.
  always_comb begin
    state_o_d    = state_q;
    bal_valid_d  = (state_q == StShow);
    balance_d    = bal_valid_d ? rd_bal : '0;
    disp_valid_d = (state_q == StUpdate) && !dep_q && (amt_q != '0);
    disp_amt_d   = disp_valid_d ? amt_q : '0;
    eject_d      = (state_q == StEject);
    retain_d     = (state_q == StRetain);
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_o_q    <= '0;
      balance_q    <= '0;
      bal_valid_q  <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_amt_q   <= '0;
      eject_q      <= 1'b0;
      retain_q     <= 1'b0;
      err_o_q      <= '0;
    end else begin
      state_o_q    <= state_o_d;
      balance_q    <= balance_d;
      bal_valid_q  <= bal_valid_d;
      disp_valid_q <= disp_valid_d;
      disp_amt_q   <= disp_amt_d;
      eject_q      <= eject_d;
      retain_q     <= retain_d;
      err_o_q      <= err_q;
    end
  end

  assign bus.state_o        = state_o_q;
  assign bus.balance_o      = balance_q;
  assign bus.balance_valid  = bal_valid_q;
  assign bus.dispense_valid = disp_valid_q;
  assign bus.dispense_amt   = disp_amt_q;
  assign bus.err_o          = err_o_q;
  assign bus.card_eject     = eject_q;
  assign bus.card_retained  = retain_q;

endmodule

// File: tb/tb_atm_multi_account_ctrl.sv
// Self-checking bench for atm_multi_account_ctrl: directed sessions plus randomized sessions,
// each checked against a per-account ledger model. Honours ATM_PIN_CHANGE_EN.
module tb_atm_multi_account_ctrl;
  import atm_pkg::*;

  localparam longint InitBal  = 1000000;
  localparam longint WdrLimit = 50000;
  localparam longint MaxBal   = 64'hFFFF_FFFF;
  localparam int     MaxTries = 3;
  localparam logic [3:0] DefPin = 4'b1010;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  atm_multi_account_ctrl_if #(.ACCT_W(2), .BAL_W(32), .PIN_W(4)) bus ();

  atm_multi_account_ctrl #(.NUM_ACCT(4), .BAL_W(32), .PIN_W(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Reference ledger.
  longint     bal_m [4];
  bit         lock_m [4];
  logic [3:0] pin_m [4];
  int         cur;
  longint     wdr_m;
  int         tries_m;
  state_e     exp_st;

  int vectors = 0;
  int miscompares = 0;

  // Pulse observers, sampled on the inactive edge.
  int     eject_cnt = 0;
  int     retain_cnt = 0;
  int     disp_cnt = 0;
  longint disp_last = 0;

  always @(negedge clk) begin
    if (bus.card_eject) eject_cnt++;
    if (bus.card_retained) retain_cnt++;
    if (bus.dispense_valid) begin
      disp_cnt++;
      disp_last = longint'(bus.dispense_amt);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    vectors++;
    assert (obs === exp_v)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (5) tick();
  endtask

  task automatic reset_model();
    for (int i = 0; i < 4; i++) begin
      bal_m[i]  = InitBal;
      lock_m[i] = 1'b0;
      pin_m[i]  = DefPin;
    end
    wdr_m  = 0;
    exp_st = StIdle;
  endtask

  task automatic check_view(input string tag, input int exp_err);
    chk({tag, "_state"}, bus.state_o, exp_st);
    chk({tag, "_err"}, bus.err_o, exp_err);
    chk({tag, "_bvalid"}, bus.balance_valid, exp_st == StShow);
    if (exp_st == StShow) chk({tag, "_balance"}, bus.balance_o, bal_m[cur]);
  endtask

  task automatic insert(input int a);
    int e0;
    e0 = eject_cnt;
    bus.card_in   = 1'b1;
    bus.card_acct = 2'(a);
    tick();
    bus.card_in = 1'b0;
    settle();
    cur     = a;
    tries_m = 0;
    if (lock_m[a]) begin
      exp_st = StIdle;
      chk("insert_locked_eject", eject_cnt - e0, 1);
      check_view("insert", 7);
    end else begin
      exp_st = StPin;
      check_view("insert", 0);
    end
  endtask

  task automatic enter_pin(input logic [3:0] p);
    int r0, e;
    r0 = retain_cnt;
    bus.pin_valid = 1'b1;
    bus.pin       = p;
    tick();
    bus.pin_valid = 1'b0;
    settle();
    e = 0;
    if (p == pin_m[cur]) begin
      exp_st = StMenu;
    end else begin
      tries_m++;
      if (tries_m >= MaxTries) begin
        lock_m[cur] = 1'b1;
        exp_st      = StIdle;
        e           = 7;
      end else begin
        e = 1;
      end
    end
    chk("pin_retain", retain_cnt - r0, (tries_m >= MaxTries) ? 1 : 0);
    check_view("pin", e);
  endtask

  task automatic do_op(input logic [2:0] code);
    int e;
    bus.op_valid = 1'b1;
    bus.op_code  = code;
    tick();
    bus.op_valid = 1'b0;
    settle();
    e = 0;
    case (code)
      3'd0: ;
      3'd1: exp_st = StShow;
      3'd2: exp_st = StDep;
      3'd3: exp_st = StWdr;
`ifdef ATM_PIN_CHANGE_EN
      3'd4: exp_st = StPinChg;
`endif
      default: e = 6;
    endcase
    check_view("op", e);
  endtask

  task automatic do_amt(input longint a);
    int d0, e;
    bit disp;
    d0 = disp_cnt;
    bus.amt_valid = 1'b1;
    bus.amount    = 32'(a);
    tick();
    bus.amt_valid = 1'b0;
    settle();
    e    = 0;
    disp = 1'b0;
    if (exp_st == StDep) begin
      if (bal_m[cur] + a > MaxBal) begin
        e      = 3;
        exp_st = StMenu;
      end else begin
        bal_m[cur] += a;
        exp_st = StShow;
      end
    end else if (exp_st == StWdr) begin
      if (a > bal_m[cur]) e = 2;
      else if (wdr_m + a > WdrLimit) e = 4;
      else begin
        bal_m[cur] -= a;
        wdr_m += a;
        disp   = (a != 0);
        exp_st = StShow;
      end
    end else begin
      pin_m[cur] = 4'(a);
      exp_st     = StShow;
    end
    chk("amt_dispense_cnt", disp_cnt - d0, disp ? 1 : 0);
    if (disp) chk("amt_dispense_amt", disp_last, a);
    check_view("amt", e);
  endtask

  task automatic do_eject(input bit with_op);
    int e0;
    e0 = eject_cnt;
    bus.eject_req = 1'b1;
    bus.op_valid  = with_op;
    bus.op_code   = 3'd1;
    tick();
    bus.eject_req = 1'b0;
    bus.op_valid  = 1'b0;
    settle();
    exp_st = StIdle;
    wdr_m  = 0;
    chk("eject_pulse", eject_cnt - e0, 1);
    check_view("eject", 0);
  endtask

  initial begin
    int n, e0, d0;
    bus.card_in   = 1'b0;
    bus.card_acct = '0;
    bus.pin_valid = 1'b0;
    bus.pin       = '0;
    bus.op_valid  = 1'b0;
    bus.op_code   = '0;
    bus.amt_valid = 1'b0;
    bus.amount    = '0;
    bus.eject_req = 1'b0;
    reset_model();
    repeat (3) tick();
    chk("rst_state", bus.state_o, 0);
    chk("rst_err", bus.err_o, 0);
    chk("rst_bvalid", bus.balance_valid, 0);
    chk("rst_balance", bus.balance_o, 0);
    chk("rst_dvalid", bus.dispense_valid, 0);
    chk("rst_damt", bus.dispense_amt, 0);
    chk("rst_eject", bus.card_eject, 0);
    chk("rst_retain", bus.card_retained, 0);
    reset_n = 1'b1;
    tick();

    // Basic withdrawal on account 2.
    insert(2);
    enter_pin(DefPin);
    do_op(3'd3);
    do_amt(300);
    chk("wdr300_balance", bus.balance_o, 999700);
    do_eject(1'b0);

    // Lockout of account 1; account 0 unaffected.
    insert(1);
    for (int i = 0; i < 3; i++) enter_pin(4'b0000);
    insert(1);
    insert(0);
    enter_pin(DefPin);
    do_op(3'd1);
    do_eject(1'b0);

    // Insufficient funds and session withdrawal limit.
    insert(0);
    enter_pin(DefPin);
    do_op(3'd3);
    do_amt(1000001);
    do_amt(40000);
    do_op(3'd3);
    do_amt(20000);
    do_amt(0);

    // Deposit overflow, then a good deposit; eject and op together: eject wins.
    do_eject(1'b1);
    insert(3);
    enter_pin(DefPin);
    do_op(3'd2);
    do_amt(MaxBal);
    do_op(3'd1);
    do_op(3'd2);
    do_amt(500);
    chk("dep500_balance", bus.balance_o, 1000500);

`ifdef ATM_PIN_CHANGE_EN
    do_op(3'd4);
    do_amt(6);
    do_eject(1'b0);
    insert(3);
    enter_pin(DefPin);
    enter_pin(4'b0110);
`else
    do_op(3'd4);
    do_op(3'd7);
    do_op(3'd0);
`endif
    do_eject(1'b1);

    // Randomized sessions.
    for (int s = 0; s < 12; s++) begin
      int a;
      int unsigned r;
      a = int'($urandom_range(0, 3));
      insert(a);
      if (exp_st == StPin) begin
        if ($urandom_range(0, 3) == 0) enter_pin(pin_m[a] ^ 4'b0001);
        enter_pin(pin_m[a]);
        for (int k = 0; k < 3; k++) begin
          r = $urandom_range(0, 2);
          if (r == 0) begin
            do_op(3'd1);
          end else if (r == 1) begin
            do_op(3'd2);
            do_amt(longint'($urandom_range(0, 100000)));
          end else begin
            do_op(3'd3);
            do_amt(longint'($urandom_range(0, 30000)));
            if (exp_st == StWdr) do_amt(0);
          end
        end
        do_eject(1'b0);
      end
    end

    // Inactivity timeout in MENU.
    insert(0);
    enter_pin(pin_m[0]);
    e0 = eject_cnt;
    n  = 0;
    while (eject_cnt == e0 && n < 1200) begin
      tick();
      n++;
    end
    chk("timeout_fired", eject_cnt - e0, 1);
    chk("timeout_window", (n >= 1010 && n <= 1030), 1);
    settle();
    exp_st = StIdle;
    wdr_m  = 0;
    check_view("timeout", 5);

    // Reset while in UPDATE: no dispense, ledger reverts.
    insert(2);
    enter_pin(pin_m[2]);
    do_op(3'd3);
    d0 = disp_cnt;
    bus.amt_valid = 1'b1;
    bus.amount    = 32'd100;
    tick();
    bus.amt_valid = 1'b0;
    tick();
    reset_n = 1'b0;
    #2;
    chk("midrst_state", bus.state_o, 0);
    chk("midrst_dvalid", bus.dispense_valid, 0);
    chk("midrst_err", bus.err_o, 0);
    repeat (2) tick();
    chk("midrst_no_dispense", disp_cnt - d0, 0);
    reset_n = 1'b1;
    reset_model();
    tick();
    insert(1);
    enter_pin(DefPin);
    do_op(3'd1);
    chk("midrst_balance", bus.balance_o, 1000000);
    do_eject(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
